// File: rtl/cnn_win_sched.sv
// 3x3 sliding-window read scheduler: walks window origins over the input RAM
// and issues nine row-major tap addresses per window, gated on RAM fill and core idle.
module cnn_win_sched #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_clr,
    input  logic [AW-1:0] wr_ptr,
    input  logic          core_bsy,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic [3:0]    tap_idx,
    output logic          win_strt,
    output logic          win_last,
    output logic          frame_done
);

    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] TWO      = AW'(2);
    localparam logic [AW-1:0] THREE    = AW'(3);
    localparam logic [AW-1:0] ROW1     = AW'(IMG_W);
    localparam logic [AW-1:0] ROW2     = AW'(2 * IMG_W);
    localparam logic [AW-1:0] LAST_OFF = AW'(2 * IMG_W + 2);
    localparam logic [AW-1:0] COL_MAX  = AW'(IMG_W - 3);
    localparam logic [AW-1:0] ROW_MAX  = AW'(IMG_H - 3);

    typedef enum logic [1:0] {
        S_WAIT,
        S_TAP,
        S_ADV,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    tap_q, tap_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] col_q, col_d;
    logic [AW-1:0] row_q, row_d;

    logic [AW-1:0] last_cur;
    logic [AW-1:0] adv_base;
    logic [AW-1:0] last_nxt;
    logic          ready_cur;
    logic          ready_nxt;
    logic          col_wrap;
    logic          frame_end;
    logic [AW-1:0] tap_off;

    assign col_wrap  = (col_q >= COL_MAX);
    assign frame_end = col_wrap && (row_q >= ROW_MAX);
    assign adv_base  = col_wrap ? (base_q + THREE) : (base_q + ONE);
    assign last_cur  = base_q + LAST_OFF;
    assign last_nxt  = adv_base + LAST_OFF;
    assign ready_cur = (last_cur < wr_ptr);
    assign ready_nxt = (last_nxt < wr_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT;
            tap_q   <= '0;
            base_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            base_q  <= base_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // ADV also performs the idle/ready check on the advanced window so that
    // back-to-back windows keep a 10-cycle cadence (9 taps + 1 advance).
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        base_d  = base_q;
        col_d   = col_q;
        row_d   = row_q;
        if (frame_clr) begin
            state_d = S_WAIT;
            tap_d   = '0;
            base_d  = '0;
            col_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (ready_cur && !core_bsy) begin
                        state_d = S_TAP;
                        tap_d   = '0;
                    end
                end
                S_TAP: begin
                    if (tap_q == 4'd8) begin
                        state_d = S_ADV;
                        tap_d   = '0;
                    end else begin
                        tap_d = tap_q + 4'd1;
                    end
                end
                S_ADV: begin
                    tap_d = '0;
                    if (frame_end) begin
                        state_d = S_DONE;
                    end else begin
                        base_d = adv_base;
                        if (col_wrap) begin
                            col_d = '0;
                            row_d = row_q + ONE;
                        end else begin
                            col_d = col_q + ONE;
                        end
                        state_d = (ready_nxt && !core_bsy) ? S_TAP : S_WAIT;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_WAIT;
                end
            endcase
        end
    end

    always_comb begin
        tap_off = '0;
        case (tap_q)
            4'd0:    tap_off = '0;
            4'd1:    tap_off = ONE;
            4'd2:    tap_off = TWO;
            4'd3:    tap_off = ROW1;
            4'd4:    tap_off = ROW1 + ONE;
            4'd5:    tap_off = ROW1 + TWO;
            4'd6:    tap_off = ROW2;
            4'd7:    tap_off = ROW2 + ONE;
            4'd8:    tap_off = ROW2 + TWO;
            default: tap_off = '0;
        endcase
    end

    always_comb begin
        rd_en      = 1'b0;
        rd_addr    = '0;
        tap_idx    = '0;
        win_strt   = 1'b0;
        win_last   = 1'b0;
        frame_done = (state_q == S_DONE);
        if (state_q == S_TAP) begin
            rd_en    = 1'b1;
            rd_addr  = base_q + tap_off;
            tap_idx  = tap_q;
            win_strt = (tap_q == 4'd0);
            win_last = (tap_q == 4'd8);
        end
    end

endmodule

// File: tb/tb_cnn_win_sched.sv
// Self-checking bench for cnn_win_sched: vector table, directed corner sequences
// and a randomized run against a window-number based reference model.
module tb_cnn_win_sched;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int AW    = 10;
    localparam int NCOL  = IMG_W - 2;
    localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_clr;
    logic [AW-1:0] wr_ptr;
    logic          core_bsy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [3:0]    tap_idx;
    logic          win_strt;
    logic          win_last;
    logic          frame_done;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cnn_win_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_clr  (frame_clr),
        .wr_ptr     (wr_ptr),
        .core_bsy   (core_bsy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .tap_idx    (tap_idx),
        .win_strt   (win_strt),
        .win_last   (win_last),
        .frame_done (frame_done)
    );

    typedef struct {
        int wp;
        int bsy;
        int clr;
        int en;
        int addr;
        int tap;
        int strt;
        int last;
        int done;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: window number, tap phase (-1 idle, 0..8 taps, 9 advance).
    int  mK;
    int  mT;
    bit  mDone;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int wp, input int bsy, input int clr);
        wr_ptr    = AW'(wp);
        core_bsy  = bsy[0];
        frame_clr = clr[0];
        tick();
    endtask

    task automatic checkOutput(input string name, input int en, input int addr, input int tap,
                               input int strt, input int last, input int done);
        logic [AW+7:0] got;
        logic [AW+7:0] want;
        got  = {rd_en, rd_addr, tap_idx, win_strt, win_last, frame_done};
        want = {1'(en), AW'(addr), 4'(tap), 1'(strt), 1'(last), 1'(done)};
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got en=%b addr=%0d tap=%0d strt=%b last=%b done=%b, want en=%0d addr=%0d tap=%0d strt=%0d last=%0d done=%0d",
                     name, rd_en, rd_addr, tap_idx, win_strt, win_last, frame_done,
                     en, addr, tap, strt, last, done);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic int mBase(input int k);
        return (k / NCOL) * IMG_W + (k % NCOL);
    endfunction

    function automatic bit mReady(input int k, input int wp);
        return (mBase(k) + 2 * IMG_W + 2) < wp;
    endfunction

    task automatic modelStep(input int wp, input int bsy, input int clr);
        if (clr != 0) begin
            mK = 0; mT = -1; mDone = 1'b0;
        end else if (mDone) begin
            mT = -1;
        end else if (mT >= 0 && mT <= 8) begin
            mT = mT + 1;
        end else if (mT == 9) begin
            mK = mK + 1;
            if (mK == NWIN) begin
                mDone = 1'b1; mT = -1;
            end else begin
                mT = (mReady(mK, wp) && bsy == 0) ? 0 : -1;
            end
        end else begin
            if (mReady(mK, wp) && bsy == 0) mT = 0;
        end
    endtask

    task automatic checkModel(input string name);
        int en;
        en = (mT >= 0 && mT <= 8) ? 1 : 0;
        checkOutput(name, en,
                    en ? mBase(mK) + (mT / 3) * IMG_W + (mT % 3) : 0,
                    en ? mT : 0,
                    (mT == 0) ? 1 : 0, (mT == 8) ? 1 : 0, mDone ? 1 : 0);
    endtask

    task automatic doReset();
        rst = 1'b1; frame_clr = 1'b0; core_bsy = 1'b0; wr_ptr = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int seqAddr[9];
        int expWrap[18];
        int addrs[$];
        int cnt, strtCnt, lastCnt, lastAddr, doneCnt, enCnt, wp, bsy, clr;
        bit hit;

        doReset();

        // Reset hold-off: one cycle from ready to tap 0, then an ADV, then a wait for wr_ptr.
        seqAddr = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
        vecs.push_back('{58, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{58, 0, 0, 0, 0, 0, 0, 0, 0});
        for (int t = 0; t < 9; t++)
            vecs.push_back('{59, 0, 0, 1, seqAddr[t], t, (t == 0), (t == 8), 0});
        vecs.push_back('{59, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{59, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{60, 0, 0, 1, 1, 0, 1, 0, 0});
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].wp, vecs[i].bsy, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].tap,
                        vecs[i].strt, vecs[i].last, vecs[i].done);
        end

        // Row wrap: windows 25 and 26 of a fully written image.
        applyStimulus(784, 0, 1);
        checkOutput("clr idle", 0, 0, 0, 0, 0, 0);
        cnt = 0;
        while (addrs.size() < 27 * 9 && cnt < 400) begin
            applyStimulus(784, 0, 0);
            if (rd_en === 1'b1) addrs.push_back(int'(rd_addr));
            cnt++;
        end
        checkValue("rowwrap taps collected", addrs.size(), 27 * 9);
        expWrap = '{25, 26, 27, 53, 54, 55, 81, 82, 83, 28, 29, 30, 56, 57, 58, 84, 85, 86};
        if (addrs.size() >= 27 * 9)
            for (int i = 0; i < 18; i++)
                checkValue($sformatf("rowwrap tap%0d", i), addrs[225 + i], expWrap[i]);

        // Core back-pressure.
        applyStimulus(784, 1, 1);
        enCnt = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(784, 1, 0);
            if (rd_en !== 1'b0) enCnt++;
        end
        checkValue("backpressure rd_en", enCnt, 0);
        applyStimulus(784, 0, 0);
        checkOutput("backpressure release", 1, 0, 0, 1, 0, 0);

        // Full frame at maximum rate, then DONE hold and clear.
        applyStimulus(784, 0, 1);
        strtCnt = 0; lastCnt = 0; lastAddr = -1;
        for (int i = 0; i < NWIN * 10; i++) begin
            applyStimulus(784, 0, 0);
            if (win_strt === 1'b1) strtCnt++;
            if (win_last === 1'b1) lastCnt++;
            if (rd_en === 1'b1) lastAddr = int'(rd_addr);
        end
        checkValue("frame win_strt count", strtCnt, NWIN);
        checkValue("frame win_last count", lastCnt, NWIN);
        checkValue("frame last address", lastAddr, IMG_W * IMG_H - 1);
        doneCnt = 0; enCnt = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(784, 0, 0);
            if (frame_done === 1'b1) doneCnt++;
            if (rd_en !== 1'b0) enCnt++;
        end
        checkValue("done held", doneCnt, 100);
        checkValue("done no rd_en", enCnt, 0);
        applyStimulus(784, 0, 1);
        checkOutput("done clr", 0, 0, 0, 0, 0, 0);

        // Abort at tap 4 of window 10.
        applyStimulus(784, 0, 1);
        strtCnt = 0; hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            applyStimulus(784, 0, 0);
            if (win_strt === 1'b1) strtCnt++;
            if (strtCnt == 11 && rd_en === 1'b1 && tap_idx == 4'd4) hit = 1'b1;
        end
        checkValue("abort reached win10 tap4", int'(hit), 1);
        checkValue("abort win10 tap4 address", int'(rd_addr), mBase(10) + IMG_W + 1);
        applyStimulus(784, 0, 1);
        checkOutput("abort next cycle", 0, 0, 0, 0, 0, 0);
        applyStimulus(784, 0, 0);
        checkOutput("abort restart", 1, 0, 0, 1, 0, 0);

        // Asynchronous reset between edges, mid-window.
        applyStimulus(784, 0, 0);
        applyStimulus(784, 0, 0);
        #2 rst = 1'b1;
        #1 checkOutput("async rst", 0, 0, 0, 0, 0, 0);
        #3 rst = 1'b0;
        tick();
        checkOutput("after async rst", 1, 0, 0, 1, 0, 0);

        // Randomized fill rate, back-pressure and occasional aborts.
        doReset();
        mK = 0; mT = -1; mDone = 1'b0;
        wp = 0;
        for (int i = 0; i < 8000; i++) begin
            clr = ($urandom_range(0, 2999) == 0) ? 1 : 0;
            bsy = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if (clr != 0) wp = $urandom_range(0, 100);
            else          wp = wp + $urandom_range(0, 3);
            if (wp > IMG_W * IMG_H) wp = IMG_W * IMG_H;
            modelStep(wp, bsy, clr);
            applyStimulus(wp, bsy, clr);
            checkModel($sformatf("random cycle %0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
